// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters,
// granting bounded bursts and holding off writes while the FIFO is full.

module fifo_wr_arbiter_chk #(
    parameter int NREQ      = 4,
    parameter int BW        = 4,
    parameter int MAX_BURST = 4
) (
    input logic            clk,
    input logic            rst,
    input logic [NREQ-1:0] grant,
    input logic [NREQ-1:0] ack,
    input logic            fifo_wr_en,
    input logic            fifo_full,
    input logic [BW-1:0]   beat_cnt
);
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_ack_in_grant: assert property (@(posedge clk) disable iff (rst) (ack & ~grant) == '0);
    a_wr_not_full:  assert property (@(posedge clk) disable iff (rst) fifo_wr_en |-> !fifo_full);
    a_beat_bound:   assert property (@(posedge clk) disable iff (rst) beat_cnt < BW'(MAX_BURST));
endmodule

module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    grant,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic [DW-1:0]      fifo_din,
    output logic               busy
);
    localparam int IW = $clog2(NREQ);
    localparam int BW = 4;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    state_t          state_r, state_nxt_s;
    logic [NREQ-1:0] grant_r, grant_nxt_s;
    logic [IW-1:0]   owner_r, owner_nxt_s;
    logic [IW-1:0]   last_winner_r, last_winner_nxt_s;
    logic [BW-1:0]   beat_cnt_r, beat_cnt_nxt_s;
    logic [IW-1:0]   pick_s;
    logic            pick_vld_s;
    logic            beat_acc_s;

    // Round-robin search starting just after the last released owner
    always_comb begin
        pick_s     = '0;
        pick_vld_s = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!pick_vld_s && req[(int'(last_winner_r) + k) % NREQ]) begin
                pick_s     = IW'((int'(last_winner_r) + k) % NREQ);
                pick_vld_s = 1'b1;
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    assign beat_acc_s = (state_r == ST_GRANT) && req[owner_r] && !fifo_full;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            grant_r       <= '0;
            owner_r       <= '0;
            last_winner_r <= IW'(NREQ - 1);
            beat_cnt_r    <= '0;
        end else begin
            state_r       <= state_nxt_s;
            grant_r       <= grant_nxt_s;
            owner_r       <= owner_nxt_s;
            last_winner_r <= last_winner_nxt_s;
            beat_cnt_r    <= beat_cnt_nxt_s;
        end
    end

    // Next-state logic: grant on request, release on dropped req or full burst
    always_comb begin
        state_nxt_s       = state_r;
        grant_nxt_s       = grant_r;
        owner_nxt_s       = owner_r;
        last_winner_nxt_s = last_winner_r;
        beat_cnt_nxt_s    = beat_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_nxt_s    = ST_GRANT;
                    grant_nxt_s    = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
                    owner_nxt_s    = pick_s;
                    beat_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[owner_r] || (beat_acc_s && beat_cnt_r == BW'(MAX_BURST - 1))) begin
                    state_nxt_s       = ST_IDLE;
                    grant_nxt_s       = '0;
                    last_winner_nxt_s = owner_r;
                    beat_cnt_nxt_s    = '0;
                end else if (beat_acc_s) begin
                    beat_cnt_nxt_s    = beat_cnt_r + 4'd1;
                end else begin
                    beat_cnt_nxt_s    = beat_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                grant_nxt_s    = '0;
                beat_cnt_nxt_s = '0;
            end
        endcase
    end

    // Output decode: ack/write only for the owner, data steered by owner index
    always_comb begin
        ack        = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        busy       = 1'b0;
        case (state_r)
            ST_GRANT: begin
                ack        = grant_r & {NREQ{beat_acc_s}};
                fifo_wr_en = beat_acc_s;
                fifo_din   = req_data[int'(owner_r) * DW +: DW];
                busy       = 1'b1;
            end
            ST_IDLE: begin
                busy       = 1'b0;
            end
            default: begin
                busy       = 1'b0;
            end
        endcase
    end

    assign grant = grant_r;

    fifo_wr_arbiter_chk #(.NREQ(NREQ), .BW(BW), .MAX_BURST(MAX_BURST)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .grant      (grant_r),
        .ack        (ack),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .beat_cnt   (beat_cnt_r)
    );
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter with NREQ=4, DW=8, MAX_BURST=4.

module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        busy;
    logic [7:0]  dat [4];
    logic [17:0] obs_v;
    logic [17:0] exp_v;
    int          errors = 0;
    int          checks = 0;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};
    assign obs_v    = {grant, ack, fifo_wr_en, busy, fifo_din};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .grant      (grant),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy)
    );

    // Requesters advance their data on the cycle after an ack
    task automatic next_cycle();
        logic [3:0] la;
        la = ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (la[i]) dat[i] = dat[i] + 8'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; fifo_full = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic release_all();
        req = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) dat[i] = 8'h55;
        rst = 1'b1; req = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000) begin
            errors++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000);
        end
        exp_v = 18'h0;
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL reset_outputs got=%h exp=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_single_owner();
        logic [7:0] ed;
        do_reset(); req = 4'b0001; dat[0] = 8'h10;
        @(negedge clk);
        exp_v = 18'h0;
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL single_cycle0 got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            ed = 8'h10 + 8'(b);
            exp_v = {4'b0001, 4'b0001, 1'b1, 1'b1, ed};
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL single_beat%0d got=%h exp=%h", b, obs_v, exp_v);
            end
            next_cycle();
        end
        @(negedge clk);
        exp_v = 18'h0;
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL single_idle got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        @(negedge clk);
        exp_v = {4'b0001, 4'b0001, 1'b1, 1'b1, 8'h14};
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL single_regrant got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        release_all();
    endtask

    task automatic test_round_robin();
        logic [7:0] ed;
        logic [3:0] oh;
        int         o;
        do_reset(); req = 4'b1111;
        dat[0] = 8'hA0; dat[1] = 8'hB0; dat[2] = 8'hC0; dat[3] = 8'hD0;
        @(negedge clk);
        next_cycle();
        for (int r = 0; r < 5; r++) begin
            o  = r % 4;
            oh = 4'b0001 << o;
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                ed = 8'hA0 + 8'(o * 16) + 8'((r / 4) * 4) + 8'(b);
                exp_v = {oh, oh, 1'b1, 1'b1, ed};
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL rr_round%0d_beat%0d got=%h exp=%h", r, b, obs_v, exp_v);
                end
                next_cycle();
            end
            @(negedge clk);
            exp_v = 18'h0;
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL rr_round%0d_idle got=%h exp=%h", r, obs_v, exp_v);
            end
            next_cycle();
        end
        release_all();
    endtask

    task automatic test_fifo_full();
        logic [7:0] ed;
        do_reset(); req = 4'b0100; dat[2] = 8'h30;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        exp_v = {4'b0100, 4'b0100, 1'b1, 1'b1, 8'h30};
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL full_beat0 got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_v = {4'b0100, 4'b0000, 1'b0, 1'b1, 8'h31};
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL full_hold%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            next_cycle();
        end
        fifo_full = 1'b0;
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            ed = 8'h30 + 8'(b);
            exp_v = {4'b0100, 4'b0100, 1'b1, 1'b1, ed};
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL full_beat%0d got=%h exp=%h", b, obs_v, exp_v);
            end
            next_cycle();
        end
        @(negedge clk);
        exp_v = 18'h0;
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL full_release got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        @(negedge clk);
        exp_v = {4'b0100, 4'b0100, 1'b1, 1'b1, 8'h34};
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL full_regrant got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        release_all();
    endtask

    task automatic test_req_drop();
        logic [7:0] ed;
        do_reset(); req = 4'b1010;
        dat[0] = 8'h10; dat[1] = 8'h50; dat[3] = 8'h90;
        @(negedge clk);
        next_cycle();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            ed = 8'h50 + 8'(b);
            exp_v = {4'b0010, 4'b0010, 1'b1, 1'b1, ed};
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL drop_beat%0d got=%h exp=%h", b, obs_v, exp_v);
            end
            next_cycle();
        end
        req = 4'b1001;
        @(negedge clk);
        exp_v = {4'b0010, 4'b0000, 1'b0, 1'b1, 8'h52};
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL drop_nowrite got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        @(negedge clk);
        exp_v = 18'h0;
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL drop_idle got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            ed = 8'h90 + 8'(b);
            exp_v = {4'b1000, 4'b1000, 1'b1, 1'b1, ed};
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL drop_owner3_beat%0d got=%h exp=%h", b, obs_v, exp_v);
            end
            next_cycle();
        end
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        exp_v = {4'b0001, 4'b0001, 1'b1, 1'b1, 8'h10};
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL drop_then_owner0 got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        release_all();
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] ed;
        do_reset(); req = 4'b0001; dat[0] = 8'h70;
        @(negedge clk);
        next_cycle();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            ed = 8'h70 + 8'(b);
            exp_v = {4'b0001, 4'b0001, 1'b1, 1'b1, ed};
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL rstmid_beat%0d got=%h exp=%h", b, obs_v, exp_v);
            end
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        exp_v = {4'b0001, 4'b0001, 1'b1, 1'b1, 8'h72};
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL rstmid_lastwrite got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        rst = 1'b0; req = 4'b1111;
        @(negedge clk);
        exp_v = 18'h0;
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL rstmid_dropped got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        @(negedge clk);
        exp_v = {4'b0001, 4'b0001, 1'b1, 1'b1, 8'h73};
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL rstmid_owner0_first got=%h exp=%h", obs_v, exp_v);
        end
        next_cycle();
        release_all();
    endtask

    task automatic test_random();
        logic [7:0] exp_nx [4];
        logic [3:0] eg;
        logic [3:0] ea;
        logic       ew;
        logic [7:0] ed;
        int         m_busy, m_owner, m_beat, m_lw, idx, found, writes;
        int         wcount [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dat[i] = 8'(i * 64); exp_nx[i] = 8'(i * 64); wcount[i] = 0;
        end
        m_busy = 0; m_owner = 0; m_beat = 0; m_lw = 3; writes = 0;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 4; i++) req[i] = ($urandom_range(0, 9) < 7);
            fifo_full = ($urandom_range(0, 9) < 2);
            @(negedge clk);
            eg = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
            ew = (m_busy != 0) && req[m_owner] && !fifo_full;
            ea = ew ? eg : 4'b0000;
            ed = (m_busy != 0) ? exp_nx[m_owner] : 8'h00;
            exp_v = {eg, ea, ew, (m_busy != 0), ed};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d got=%h exp=%h", n, obs_v, exp_v);
                break;
            end
            if (ew) begin
                exp_nx[m_owner] = exp_nx[m_owner] + 8'd1;
                wcount[m_owner]++;
                writes++;
            end
            if (m_busy == 0) begin
                if (req != 4'b0000) begin
                    found = 0;
                    for (int k = 1; k <= 4; k++) begin
                        idx = (m_lw + k) % 4;
                        if (found == 0 && req[idx]) begin m_owner = idx; found = 1; end
                    end
                    m_busy = 1; m_beat = 0;
                end
            end else if (!req[m_owner] || (ew && m_beat == 3)) begin
                m_lw = m_owner; m_busy = 0; m_beat = 0;
            end else if (ew) begin
                m_beat++;
            end
            next_cycle();
        end
        checks++;
        if (writes < 1000) begin
            errors++; $display("FAIL random_write_volume got=%0d exp>=%0d", writes, 1000);
        end
        checks++;
        if (wcount[0] == 0 || wcount[1] == 0 || wcount[2] == 0 || wcount[3] == 0) begin
            errors++;
            $display("FAIL random_all_served got=%0d/%0d/%0d/%0d exp=all nonzero",
                     wcount[0], wcount[1], wcount[2], wcount[3]);
        end
        release_all();
    endtask

    initial begin
        test_reset();
        test_single_owner();
        test_round_robin();
        test_fifo_full();
        test_req_drop();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
